rom_select: RTL
===============

# rom_select

Front-panel ROM selector between the board's single select button and the flash ROM loader (`main_mem`). It synchronises and debounces the raw pin and classifies presses as short or long. A short press advances the ROM slot index; a long press reloads the current slot. It issues a one-cycle `reload` pulse to the loader and tracks the loader's `load_done` handshake so that new requests are never issued mid-load.

## Interface
- `NUM_ROMS`, 8: number of ROM slots in flash (1–16); index wraps at this value.
- `INIT_INDEX`, 0: slot selected after reset (< `NUM_ROMS`).
- `DEBOUNCE_CYCLES`, 262144: cycles the synchronised input must hold a new level before it is accepted.
- `LONG_CYCLES`, 16777216: debounced hold time at or above which a press is long.
- `DROP_TIMEOUT`, 255: cycles to wait for `load_done` to fall after `reload`.

Ports:
- `clock`  in  1  system clock (the NES master clock domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_n`  in  1  raw button pin, active-low (pulled up), asynchronous to `clock`.
- `load_done`  in  1  loader status; high when the current image is loaded.
- `reload`  out  1  one-cycle request pulse to the loader.
- `index`  out  4  selected slot; drives the loader's slot index.
- `busy`  out  1  high from the `reload` pulse until the load completes or times out.
- `pressed`  out  1  debounced button state (1 = held); for LED use.

## Operation
- Sync: `btn_n` passes through 2 flops, reset to 1 (released).
- Debounce: `stable` register, reset to released. The counter clears whenever the synchronised input equals `stable`. Otherwise it increments; at `DEBOUNCE_CYCLES-1` the `stable` register takes the input and the counter clears. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- Hold counter: clears on the press edge and increments while pressed. It saturates at `LONG_CYCLES`.
- FSM states:
  - IDLE:
    - Press edge → PRESS.
  - PRESS:
    - Hold count reaches `LONG_CYCLES-1` → LONG: request reload of the same index.
    - Release edge before that → SHORT: `index` ← `index+1`, or 0 when it equals `NUM_ROMS-1`. Then → REQ.
  - LONG:
    - Waits for release, then → REQ. No repeat while held.
  - REQ:
    - `reload`=1 for exactly this cycle; `busy` set.
    - → WAIT_DROP.
  - WAIT_DROP:
    - `load_done`==0 → WAIT_DONE.
    - Drop counter reaches `DROP_TIMEOUT` → IDLE, `busy` cleared.
  - WAIT_DONE:
    - `load_done`==1 → IDLE, `busy` cleared.
- Press edges in REQ, WAIT_DROP or WAIT_DONE are ignored entirely: no index change and no queueing. A release edge seen there does nothing.
- If the button is still held on return to IDLE, no press is registered until it is released and pressed again.
- SHORT is a transient step inside the PRESS→REQ transition, not a state occupying a cycle. `index` updates in the same cycle that the FSM enters REQ.

## Timing
- Reset values: `reload`=0, `busy`=0, `pressed`=0, `index`=`INIT_INDEX`, FSM=IDLE, all counters 0.
- Input to `pressed` latency: 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
- Short press:
  - The release acceptance cycle updates `index` and enters REQ.
  - `reload` is high on the next clock edge's output and lasts exactly 1 cycle.
- Long press:
  - No `reload` occurs until release is debounced.
  - `reload` follows the release by 1 cycle; `index` is unchanged.
- `busy` rises in the same cycle as `reload`. It falls the cycle after `load_done` is seen high in WAIT_DONE.
- `load_done` is sampled directly; it is in the `clock` domain.
- Reset asserted mid-load: all state returns to reset values immediately.
  - `index` returns to `INIT_INDEX`.
  - A `reload` pulse in flight is cut off.
- Glitches shorter than `DEBOUNCE_CYCLES` never change `pressed`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=8, `LONG_CYCLES`=64, `NUM_ROMS`=3, `DROP_TIMEOUT`=16. The loader model drops `load_done` 2 cycles after `reload` and raises it 20 cycles later.

1. Reset: hold `reset_n`=0 with `btn_n` toggling. Required: `reload`=0, `busy`=0, `pressed`=0, `index`=0.
2. Short press: hold `btn_n` low 30 cycles, then release. Required: `index` 0→1, a single 1-cycle `reload`, and `busy` high until 1 cycle after `load_done` rises.
3. Wrap and bounce:
   - Three short presses give `index` sequence 1, 2, 0.
   - 5-cycle low glitches between presses leave `pressed` and `index` unchanged.
4. Long press: hold `btn_n` low 200 cycles, then release. Required: exactly one `reload` after the release debounces, `index` unchanged.
5. Busy lockout and timeout:
   - A press during WAIT_DONE gives no `index` change and no second `reload`.
   - With `load_done` stuck at 1, `busy` clears 16 cycles after `reload`.
6. Reset mid-load: assert `reset_n` low during WAIT_DONE with `index`=2. Required: `busy`=0 and `index`=0 immediately; after release, IDLE is re-entered.

Source files
------------

// File: rtl/rom_select.sv
// rom_select: front-panel ROM slot selector.
// Debounces the select button, classifies presses and requests reloads.
module rom_select #(
    parameter int NUM_ROMS        = 8,
    parameter int INIT_INDEX      = 0,
    parameter int DEBOUNCE_CYCLES = 262144,
    parameter int LONG_CYCLES     = 16777216,
    parameter int DROP_TIMEOUT    = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       load_done,
    output logic       reload,
    output logic [3:0] index,
    output logic       busy,
    output logic       pressed
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW  = $clog2(LONG_CYCLES + 1);
    localparam int DW  = $clog2(DROP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_LONG,
        S_REQ,
        S_WAIT_DROP,
        S_WAIT_DONE
    } state_t;

    logic           sync1_q;
    logic           sync2_q;
    logic           stable_q;
    logic           stable_d;
    logic           stable_prev_q;
    logic [DBW-1:0] db_cnt_q;
    logic [DBW-1:0] db_cnt_d;
    logic [HW-1:0]  hold_cnt_q;
    logic [HW-1:0]  hold_cnt_d;
    logic [DW-1:0]  drop_cnt_q;
    logic [DW-1:0]  drop_cnt_d;
    logic [DW-1:0]  drop_next;
    logic [3:0]     index_q;
    logic [3:0]     index_d;
    state_t         state_q;
    state_t         state_d;
    logic           reload_q;
    logic           reload_d;
    logic           busy_q;
    logic           busy_d;
    logic           press_edge;
    logic           release_edge;

    // stable_q is the debounced pin level, so low means held
    assign press_edge   = stable_prev_q & ~stable_q;
    assign release_edge = ~stable_prev_q & stable_q;
    assign drop_next    = drop_cnt_q + 1'b1;

    assign reload  = reload_q;
    assign busy    = busy_q;
    assign index   = index_q;
    assign pressed = ~stable_q;

    // Debounce: accept a new level only after it holds for the full window
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Hold timer: restarts on each press, saturates so it never wraps
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (press_edge) begin
            hold_cnt_d = '0;
        end else if (!stable_q && hold_cnt_q != HW'(LONG_CYCLES)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Press classification and loader handshake; edges outside PRESS are dropped
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        reload_d   = 1'b0;
        busy_d     = busy_q;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (press_edge) begin
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
                    state_d = S_LONG;
                end else if (release_edge) begin
                    index_d  = (index_q == 4'(NUM_ROMS - 1)) ? 4'd0
                                                             : index_q + 1'b1;
                    state_d  = S_REQ;
                    reload_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_LONG: begin
                if (stable_q) begin
                    state_d  = S_REQ;
                    reload_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_REQ: begin
                // the reload cycle itself counts toward the drop timeout
                drop_cnt_d = DW'(1);
                state_d    = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                if (!load_done) begin
                    drop_cnt_d = '0;
                    state_d    = S_WAIT_DONE;
                end else if (drop_next == DW'(DROP_TIMEOUT)) begin
                    drop_cnt_d = '0;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    drop_cnt_d = drop_next;
                end
            end
            S_WAIT_DONE: begin
                if (load_done) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin synchroniser and debounce state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            db_cnt_q      <= '0;
            hold_cnt_q    <= '0;
        end else begin
            sync1_q       <= btn_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    // FSM state and its registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            index_q    <= 4'(INIT_INDEX);
            reload_q   <= 1'b0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            reload_q   <= reload_d;
            busy_q     <= busy_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
